mem_arbiter: RTL and testbench

Shares the single main-memory block port between the I-cache controller and the D-cache controller. Each controller presents a block-granular read (or, for the D-cache, write) request. The arbiter grants one requester at a time, drives the memory port from registers and returns the captured read block or a write-complete pulse. It keeps a D-cache writeback plus refill pair atomic and otherwise alternates grants round-robin.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr.sv | 21 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM states and round-robin pointer encodings for mem_arbiter.
package mem_arbiter_pkg;
  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_BLOCK_W = 128;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_e;
  localparam logic PTR_I = 1'b0;
  localparam logic PTR_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-requester round-robin grant with a registered pointer (bit0 = I-cache, bit1 = D-cache).
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       ptr_in,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    ptr_d = upd ? ptr_in : ptr_q;
    gnt   = (req == 2'b11) ? (ptr_q == PTR_D ? 2'b10 : 2'b01) : req;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= PTR_D;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-granular memory port between the I-cache and D-cache controllers.
// All outputs are registered; a D writeback forces the pointer to D so its refill stays atomic.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int BLOCK_W = MEM_BLOCK_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iRen,
  input  logic [ADDR_W-1:0]  iBlockAddr,
  output logic               iReadReady,
  output logic [BLOCK_W-1:0] iDout,
  input  logic               dRen,
  input  logic               dWen,
  input  logic [ADDR_W-1:0]  dBlockAddr,
  input  logic [BLOCK_W-1:0] dDin,
  output logic               dReadReady,
  output logic               dWriteDone,
  output logic [BLOCK_W-1:0] dDout,
  output logic               memRen,
  output logic               memWen,
  output logic [ADDR_W-1:0]  memBlockAddr,
  output logic [BLOCK_W-1:0] memDin,
  input  logic               memReadReady,
  input  logic [BLOCK_W-1:0] memDout,
  input  logic               memWriteDone,
  output logic               busy
);
  state_e state_q, state_d;
  logic wr_q, wr_d, ren_q, ren_d, wen_q, wen_d;
  logic irdy_q, irdy_d, drdy_q, drdy_d, dwd_q, dwd_d, busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] din_q, din_d, idout_q, idout_d, ddout_q, ddout_d;
  logic [1:0] gnt;
  logic upd, ptr_in;

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    ({dRen | dWen, iRen}),
    .upd    (upd),
    .ptr_in (ptr_in),
    .gnt    (gnt)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    din_d   = din_q;
    idout_d = idout_q;
    ddout_d = ddout_q;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
    dwd_d   = 1'b0;
    upd     = 1'b0;
    ptr_in  = PTR_D;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          state_d = GRANT_I;
          addr_d  = iBlockAddr;
          wr_d    = 1'b0;
          ren_d   = 1'b1;
        end else if (gnt[1]) begin
          state_d = GRANT_D;
          addr_d  = dBlockAddr;
          wr_d    = dWen;
          ren_d   = !dWen;
          wen_d   = dWen;
          din_d   = dWen ? dDin : din_q;
        end
      end
      GRANT_I: begin
        if (memReadReady) begin
          state_d = RELEASE;
          idout_d = memDout;
          irdy_d  = 1'b1;
          ren_d   = 1'b0;
          upd     = 1'b1;
          ptr_in  = PTR_D;
        end
      end
      GRANT_D: begin
        // the handshake for the other operation type is ignored while granted
        if (wr_q && memWriteDone) begin
          state_d = RELEASE;
          dwd_d   = 1'b1;
          wen_d   = 1'b0;
          upd     = 1'b1;
          ptr_in  = PTR_D;
        end else if (!wr_q && memReadReady) begin
          state_d = RELEASE;
          ddout_d = memDout;
          drdy_d  = 1'b1;
          ren_d   = 1'b0;
          upd     = 1'b1;
          ptr_in  = PTR_I;
        end
      end
      RELEASE: state_d = (!memReadReady && !memWriteDone) ? IDLE : RELEASE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      idout_q <= '0;
      ddout_q <= '0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      dwd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      idout_q <= idout_d;
      ddout_q <= ddout_d;
      irdy_q  <= irdy_d;
      drdy_q  <= drdy_d;
      dwd_q   <= dwd_d;
      busy_q  <= busy_d;
    end
  end

  assign memRen       = ren_q;
  assign memWen       = wen_q;
  assign memBlockAddr = addr_q;
  assign memDin       = din_q;
  assign iDout        = idout_q;
  assign dDout        = ddout_q;
  assign iReadReady   = irdy_q;
  assign dReadReady   = drdy_q;
  assign dWriteDone   = dwd_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with a read-data scoreboard for mem_arbiter.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int BW = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iRen = 1'b0, dRen = 1'b0, dWen = 1'b0;
  logic [AW-1:0] iBlockAddr = '0, dBlockAddr = '0;
  logic [BW-1:0] dDin = '0, memDout = '0;
  logic          memReadReady = 1'b0, memWriteDone = 1'b0;
  logic          iReadReady, dReadReady, dWriteDone, memRen, memWen, busy;
  logic [BW-1:0] iDout, dDout, memDin;
  logic [AW-1:0] memBlockAddr;

  int checks = 0;
  int failures = 0;
  int wd_cnt = 0;
  logic [BW-1:0] i_obs[$], d_obs[$], i_exp[$], d_exp[$];

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .iRen(iRen), .iBlockAddr(iBlockAddr), .iReadReady(iReadReady), .iDout(iDout),
    .dRen(dRen), .dWen(dWen), .dBlockAddr(dBlockAddr), .dDin(dDin),
    .dReadReady(dReadReady), .dWriteDone(dWriteDone), .dDout(dDout),
    .memRen(memRen), .memWen(memWen), .memBlockAddr(memBlockAddr), .memDin(memDin),
    .memReadReady(memReadReady), .memDout(memDout), .memWriteDone(memWriteDone),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (iReadReady) i_obs.push_back(iDout);
    if (dReadReady) d_obs.push_back(dDout);
    if (dWriteDone) wd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic wr);
    int n = 0;
    while ((wr ? memWen : memRen) !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    assert (n < 20) else begin
      failures++;
      $error("FAIL %s observed=timeout expected=grant", tag);
    end
  endtask

  task automatic pop_cmp(input string tag, input bit is_d);
    int no = is_d ? d_obs.size() : i_obs.size();
    int ne = is_d ? d_exp.size() : i_exp.size();
    logic [BW-1:0] o, e;
    checks++;
    assert (no > 0 && ne > 0) else begin
      failures++;
      $error("FAIL %s observed=%0d_entries expected=%0d_entries", tag, no, ne);
    end
    if (no > 0 && ne > 0) begin
      o = is_d ? d_obs.pop_front() : i_obs.pop_front();
      e = is_d ? d_exp.pop_front() : i_exp.pop_front();
      chk(tag, o, e);
    end
  endtask

  task automatic respond(input logic [BW-1:0] data, input int hold);
    memDout = data;
    memReadReady = 1'b1;
    repeat (hold) @(negedge clock);
    memReadReady = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] data;
    bit order_d[3] = '{1'b1, 1'b0, 1'b1};
    bit seen;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_memRen", memRen, 0);
    chk("rst_memWen", memWen, 0);
    chk("rst_addr", memBlockAddr, 0);
    chk("rst_iDout", iDout, 0);
    chk("rst_dDout", dDout, 0);
    reset = 1'b1;
    @(negedge clock);

    // single I-cache read, long memReadReady
    iBlockAddr = 16'h0041;
    iRen = 1'b1;
    wait_req("t1_grant", 1'b0);
    chk("t1_addr", memBlockAddr, 16'h0041);
    chk("t1_busy", busy, 1);
    iRen = 1'b0;
    data = 128'hAA << 120;
    i_exp.push_back(data);
    memDout = data;
    memReadReady = 1'b1;
    @(negedge clock);
    chk("t1_pulse", iReadReady, 1);
    chk("t1_memRen_drop", memRen, 0);
    chk("t1_iDout", iDout, data);
    repeat (9) @(negedge clock);
    chk("t1_busy_release", busy, 1);
    chk("t1_pulse_once", iReadReady, 0);
    memReadReady = 1'b0;
    @(negedge clock);
    chk("t1_busy_idle", busy, 0);
    pop_cmp("t1_i_data", 1'b0);

    // both readers: D, I, D
    iBlockAddr = 16'h0100;
    dBlockAddr = 16'h0200;
    iRen = 1'b1;
    dRen = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req("t2_grant", 1'b0);
      chk("t2_order_addr", memBlockAddr, order_d[k] ? 16'h0200 : 16'h0100);
      if (k == 2) begin
        iRen = 1'b0;
        dRen = 1'b0;
      end
      data = {96'h0, 8'(k + 1), 8'(order_d[k]), 16'h5A5A};
      if (order_d[k]) d_exp.push_back(data);
      else i_exp.push_back(data);
      respond(data, 2);
    end
    @(negedge clock);
    pop_cmp("t2_d0", 1'b1);
    pop_cmp("t2_i0", 1'b0);
    pop_cmp("t2_d1", 1'b1);

    // writeback then refill, I-cache pending throughout
    dBlockAddr = 16'h0F0C;
    dDin = 128'h2 << 124;
    dWen = 1'b1;
    wait_req("t3_wb_grant", 1'b1);
    iBlockAddr = 16'h0300;
    iRen = 1'b1;
    chk("t3_wb_memRen", memRen, 0);
    chk("t3_wb_addr", memBlockAddr, 16'h0F0C);
    chk("t3_wb_din", memDin, 128'h2 << 124);
    memWriteDone = 1'b1;
    @(negedge clock);
    chk("t3_wdone", dWriteDone, 1);
    chk("t3_memWen_drop", memWen, 0);
    dWen = 1'b0;
    dRen = 1'b1;
    @(negedge clock);
    memWriteDone = 1'b0;
    wait_req("t3_refill_grant", 1'b0);
    chk("t3_refill_addr", memBlockAddr, 16'h0F0C);
    dRen = 1'b0;
    data = 128'h0123_4567_89AB_CDEF;
    d_exp.push_back(data);
    respond(data, 1);
    wait_req("t3_i_grant", 1'b0);
    chk("t3_i_addr", memBlockAddr, 16'h0300);
    iRen = 1'b0;
    data = 128'hFEDC_0000_0000_0000_0000_0000_0000_0003;
    i_exp.push_back(data);
    respond(data, 1);
    @(negedge clock);
    pop_cmp("t3_refill_data", 1'b1);
    pop_cmp("t3_i_data", 1'b0);
    chk("t3_wd_cnt", wd_cnt, 1);

    // dRen and dWen together is a write; stray memReadReady ignored
    dBlockAddr = 16'h0055;
    dDin = 128'hDEAD_BEEF;
    dRen = 1'b1;
    dWen = 1'b1;
    wait_req("t4_grant", 1'b1);
    chk("t4_memRen", memRen, 0);
    chk("t4_din", memDin, 128'hDEAD_BEEF);
    dRen = 1'b0;
    dWen = 1'b0;
    memDout = 128'hBAD0;
    memReadReady = 1'b1;
    repeat (2) @(negedge clock);
    chk("t4_wen_held", memWen, 1);
    memReadReady = 1'b0;
    memWriteDone = 1'b1;
    @(negedge clock);
    memWriteDone = 1'b0;
    repeat (2) @(negedge clock);
    chk("t4_wd_cnt", wd_cnt, 2);
    chk("t4_no_dread", d_obs.size(), 0);
    chk("t4_idle", busy, 0);

    // asynchronous reset mid-transaction
    dBlockAddr = 16'h0066;
    dRen = 1'b1;
    wait_req("t5_grant", 1'b0);
    dRen = 1'b0;
    memDout = 128'hBAD1;
    memReadReady = 1'b1;
    reset = 1'b0;
    #1;
    chk("t5_async_memRen", memRen, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_addr", memBlockAddr, 0);
    chk("t5_async_din", memDin, 0);
    chk("t5_async_iDout", iDout, 0);
    chk("t5_async_dDout", dDout, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("t5_post_busy", busy, 0);
    chk("t5_post_memRen", memRen, 0);
    memReadReady = 1'b0;
    @(negedge clock);
    chk("t5_no_pulse", d_obs.size(), 0);
    dBlockAddr = 16'h0077;
    dRen = 1'b1;
    wait_req("t5_new_grant", 1'b0);
    chk("t5_new_addr", memBlockAddr, 16'h0077);
    dRen = 1'b0;
    data = 128'h77;
    d_exp.push_back(data);
    respond(data, 1);
    @(negedge clock);
    pop_cmp("t5_new_data", 1'b1);

    // memReadReady held through RELEASE with iRen pending
    iBlockAddr = 16'h0088;
    iRen = 1'b1;
    wait_req("t6_grant", 1'b0);
    data = 128'h8888_0001;
    i_exp.push_back(data);
    memDout = data;
    memReadReady = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      seen |= memRen;
    end
    chk("t6_no_regrant", seen, 0);
    memReadReady = 1'b0;
    wait_req("t6_regrant", 1'b0);
    iRen = 1'b0;
    data = 128'h8888_0002;
    i_exp.push_back(data);
    respond(data, 1);
    @(negedge clock);
    pop_cmp("t6_first", 1'b0);
    pop_cmp("t6_second", 1'b0);

    chk("end_i_left", i_obs.size(), 0);
    chk("end_d_left", d_obs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
